// File: rtl/pc_ctrl_if.sv
// Purpose: bundles the control-side request inputs and the PC/flush outputs
//          of pc_control_unit into one interface.
// Signals:
//   in_stall            - hold all state this cycle
//   in_ctrl_branch      - conditional redirect request
//   in_ctrl_btype       - condition select (00 zero, 01 neg, 10 neg|zero, 11 ~zero)
//   in_ctrl_jump        - unconditional redirect request
//   in_ctrl_neg/zero    - ALU flags feeding the branch condition
//   in_target           - redirect destination
//   out_pc              - current fetch PC (registered)
//   out_taken           - redirect decision for the current cycle (combinational)
//   out_flush           - squash younger stages (registered)
//   out_redirect_count  - saturating count of accepted redirects (registered)
// Modports: master drives the requests, slave is the PC unit.
interface pc_ctrl_if #(
    parameter int unsigned PC_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 in_stall;
    logic                 in_ctrl_branch;
    logic [1:0]           in_ctrl_btype;
    logic                 in_ctrl_jump;
    logic                 in_ctrl_neg;
    logic                 in_ctrl_zero;
    logic [PC_WIDTH-1:0]  in_target;
    logic [PC_WIDTH-1:0]  out_pc;
    logic                 out_taken;
    logic                 out_flush;
    logic [CNT_WIDTH-1:0] out_redirect_count;

    modport master (
        output in_stall, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
               in_ctrl_neg, in_ctrl_zero, in_target,
        input  out_pc, out_taken, out_flush, out_redirect_count
    );

    modport slave (
        input  in_stall, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
               in_ctrl_neg, in_ctrl_zero, in_target,
        output out_pc, out_taken, out_flush, out_redirect_count
    );
endinterface

// File: rtl/pc_control_unit.sv
// Purpose: program counter sequencer with branch/jump redirect, a fixed
//          number of flush bubbles after each taken redirect, and a
//          saturating redirect counter.
// Ports:
//   clock - single rising-edge clock
//   reset - asynchronous, active-high
//   bus   - pc_ctrl_if slave: stall, branch/jump requests, ALU flags,
//           target in; out_pc, out_taken, out_flush, out_redirect_count out
module pc_control_unit #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    pc_ctrl_if.slave   bus
);

    localparam int unsigned FCNT_W = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [FCNT_W-1:0]    r_fcnt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_flush;

    state_t               w_state_nxt;
    logic [PC_WIDTH-1:0]  w_pc_nxt;
    logic [FCNT_W-1:0]    w_fcnt_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_cond;
    logic                 w_taken;

    // State register; out_flush is registered from the next state so it
    // rises on the same edge that loads the redirect target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= PC_WIDTH'(RESET_PC);
            r_fcnt  <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flush <= (w_state_nxt == ST_FLUSH);
        end
    end

    // Branch condition, redirect decision and next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fcnt_nxt  = r_fcnt;
        w_cnt_nxt   = r_cnt;
        w_cond      = 1'b0;

        case (bus.in_ctrl_btype)
            2'b00:   w_cond = bus.in_ctrl_zero;
            2'b01:   w_cond = bus.in_ctrl_neg;
            2'b10:   w_cond = bus.in_ctrl_neg | bus.in_ctrl_zero;
            default: w_cond = ~bus.in_ctrl_zero;
        endcase

        // Jump and branch share one target, so OR-ing them is jump-wins.
        w_taken = (r_state == ST_RUN) & ~bus.in_stall &
                  (bus.in_ctrl_jump | (bus.in_ctrl_branch & w_cond));

        case (r_state)
            ST_RUN: begin
                if (!bus.in_stall) begin
                    if (w_taken) begin
                        w_pc_nxt = bus.in_target;
                        if (r_cnt != CNT_MAX) begin
                            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                        end
                        if (FLUSH_DEPTH != 0) begin
                            w_state_nxt = ST_FLUSH;
                            w_fcnt_nxt  = FCNT_W'(FLUSH_DEPTH);
                        end
                    end else begin
                        w_pc_nxt = r_pc + PC_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.in_stall) begin
                    w_pc_nxt   = r_pc + PC_WIDTH'(1);
                    w_fcnt_nxt = r_fcnt - FCNT_W'(1);
                    // <=1 also recovers from a zero count should one appear.
                    if (r_fcnt <= FCNT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_fcnt_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.out_pc             = r_pc;
    assign bus.out_taken          = w_taken;
    assign bus.out_flush          = r_flush;
    assign bus.out_redirect_count = r_cnt;

endmodule
